systolic_skew_feeder: RTL and testbench

- Upstream feeder for the west edge of the FP16 systolic array: one column of A (one element per row) is accepted per cycle and emitted to row r delayed by r cycles, forming the diagonal wavefront the processing elements need.
- Generates a per-row done pulse, timed so each row's PEs see the done flag only after their last product has entered the accumulator.
- Sits between the A-operand buffer (valid/ready) and the PE west inputs / done-flag inputs.

---
 rtl/fp16_pkg.sv | 23 ++
 rtl/skew_delay_line.sv | 36 +++
 rtl/systolic_skew_feeder.sv | 124 ++++++++++++
 tb/tb_systolic_skew_feeder.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared FP16 constants and the skew-feeder state encoding.
// Arithmetic-core latencies here set the default done-flag delay of the feeder.
package fp16_pkg;

    localparam int FP_WIDTH  = 16;
    localparam int EXP_BITS  = 5;
    localparam int FRAC_BITS = 10;

    localparam logic [FP_WIDTH-1:0] FP16_ZERO = 16'h0000;

    localparam int MULT_LATENCY = 1;
    localparam int ADD_LATENCY  = 1;

    // Multiplier output, then one accumulate cycle, before a row may see done.
    localparam int DEFAULT_DONE_DELAY = MULT_LATENCY + ADD_LATENCY + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } feeder_state_e;

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register with synchronous reset; DEPTH=0 is a plain wire.
// Used for both the per-row data skew and the per-row done-marker delay.
module skew_delay_line #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    if (DEPTH == 0) begin : g_pass
        logic w_unused_clk_rst;
        assign w_unused_clk_rst = clk | reset;
        assign o_q = i_d;
    end else begin : g_shift
        logic [WIDTH-1:0] r_stage [DEPTH];

        always_ff @(posedge clk) begin
            if (reset) begin
                // NOTE: every stage is cleared so a reset mid-stream cannot leak stale data or a done marker.
                r_stage <= '{default: '0};
            end else begin
                // NOTE: non-blocking assignments let each stage take its neighbour's pre-edge value.
                r_stage[0] <= i_d;
                for (int i = 1; i < DEPTH; i++) begin
                    r_stage[i] <= r_stage[i-1];
                end
            end
        end

        assign o_q = r_stage[DEPTH-1];
    end

endmodule

// File: rtl/systolic_skew_feeder.sv
// West-edge feeder for the FP16 systolic array: one A column in per cycle,
// row r delayed by r extra cycles, plus a per-row done pulse after the last product.
module systolic_skew_feeder
    import fp16_pkg::*;
#(
    parameter int WIDTH      = FP_WIDTH,
    parameter int ROWS       = 4,
    parameter int DONE_DELAY = DEFAULT_DONE_DELAY,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [ROWS*WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic [ROWS*WIDTH-1:0] out_a,
    output logic [ROWS-1:0]       done,
    output logic                  busy,
    output logic [CNT_W-1:0]      k_count
);

    localparam int FLUSH_CYCLES = ROWS + DONE_DELAY;
    localparam int FLUSH_W      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(FLUSH_CYCLES - 1);

    feeder_state_e         r_state;
    feeder_state_e         w_state_nxt;
    logic [FLUSH_W-1:0]    r_flush_cnt;
    logic [FLUSH_W-1:0]    w_flush_cnt_nxt;
    logic [CNT_W-1:0]      r_k_count;
    logic [CNT_W-1:0]      w_k_count_nxt;
    logic [ROWS*WIDTH-1:0] r_inject;
    logic                  r_last_mark;
    logic                  w_accept;

    assign s_ready  = !reset && (r_state != ST_FLUSH);
    assign w_accept = s_valid && s_ready;
    assign busy     = (r_state != ST_IDLE);
    assign k_count  = r_k_count;

    always_comb begin
        // NOTE: defaults first, so no path through the case can infer a latch.
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_k_count_nxt   = r_k_count;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_k_count_nxt = CNT_W'(1);
                    if (s_last) begin
                        w_state_nxt     = ST_FLUSH;
                        w_flush_cnt_nxt = FLUSH_LOAD;
                    end else begin
                        w_state_nxt = ST_STREAM;
                    end
                end
            end
            ST_STREAM: begin
                if (w_accept) begin
                    if (r_k_count != '1) begin
                        w_k_count_nxt = r_k_count + CNT_W'(1);
                    end
                    if (s_last) begin
                        w_state_nxt     = ST_FLUSH;
                        w_flush_cnt_nxt = FLUSH_LOAD;
                    end
                end
            end
            ST_FLUSH: begin
                // Last FLUSH cycle is the one where the bottom row's done fires.
                if (r_flush_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt - FLUSH_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_flush_cnt <= '0;
            r_k_count   <= '0;
            r_inject    <= '0;
            r_last_mark <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_k_count   <= w_k_count_nxt;
            // Bubbles are FP16 +0, which leaves every accumulator unchanged.
            r_inject    <= w_accept ? s_data : {ROWS{WIDTH'(FP16_ZERO)}};
            r_last_mark <= w_accept && s_last;
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        skew_delay_line #(
            .WIDTH (WIDTH),
            .DEPTH (r)
        ) u_data_skew (
            .clk   (clk),
            .reset (reset),
            .i_d   (r_inject[r*WIDTH +: WIDTH]),
            .o_q   (out_a[r*WIDTH +: WIDTH])
        );

        skew_delay_line #(
            .WIDTH (1),
            .DEPTH (r + DONE_DELAY)
        ) u_done_skew (
            .clk   (clk),
            .reset (reset),
            .i_d   (r_last_mark),
            .o_q   (done[r])
        );
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench: a cycle-history model predicts every output each cycle,
// and directed vectors pin literal values for the 4-row and 1-row configurations.
module tb_systolic_skew_feeder;

    localparam int NCYC = 1024;
    localparam int W    = 16;
    localparam int ROWS_CFG [2] = '{4, 1};
    localparam int DD_CFG   [2] = '{3, 0};

    localparam logic [63:0] T1_OUT [8] = '{
        64'h0000_0000_0000_3C00, 64'h0000_0000_4000_0000,
        64'h0000_4200_0000_0000, 64'h4400_0000_0000_0000,
        64'h0, 64'h0, 64'h0, 64'h0};
    localparam logic [3:0] T1_DONE [8] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
    localparam logic [15:0] T2_ROW2 [3] = '{16'h3C00, 16'h4000, 16'h4200};

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid [2];
    logic [63:0] in_data  [2];
    logic        in_last  [2];

    logic        rdy4, busy4;
    logic [63:0] out_a4;
    logic [3:0]  done4;
    logic [15:0] k4;
    logic        rdy1, busy1;
    logic [15:0] out_a1;
    logic [0:0]  done1;
    logic [15:0] k1;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // Model state: what was injected each cycle, where s_last was accepted.
    logic [63:0] m_inj     [2][NCYC];
    bit          m_lastacc [2][NCYC];
    bit          m_streaming [2] = '{1'b0, 1'b0};
    int          m_flush_end [2] = '{-1, -1};
    logic [15:0] m_k         [2] = '{16'h0, 16'h0};
    int          m_last_rst = -1;

    systolic_skew_feeder #(.WIDTH(16), .ROWS(4), .DONE_DELAY(3), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .s_valid(in_valid[0]), .s_ready(rdy4),
        .s_data(in_data[0]), .s_last(in_last[0]), .out_a(out_a4),
        .done(done4), .busy(busy4), .k_count(k4));

    systolic_skew_feeder #(.WIDTH(16), .ROWS(1), .DONE_DELAY(0), .CNT_W(16)) dut_r1 (
        .clk(clk), .reset(reset), .s_valid(in_valid[1]), .s_ready(rdy1),
        .s_data(in_data[1][15:0]), .s_last(in_last[1]), .out_a(out_a1),
        .done(done1), .busy(busy1), .k_count(k1));

    initial forever #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [63:0] exp_out(int d, int t);
        logic [63:0] v;
        v = '0;
        for (int r = 0; r < ROWS_CFG[d]; r++) begin
            int c;
            c = t - 1 - r;
            if (c >= 0 && c > m_last_rst) v[r*W +: W] = m_inj[d][c][r*W +: W];
        end
        return v;
    endfunction

    function automatic logic [3:0] exp_done(int d, int t);
        logic [3:0] v;
        v = '0;
        for (int r = 0; r < ROWS_CFG[d]; r++) begin
            int c;
            c = t - 1 - r - DD_CFG[d];
            if (c >= 0 && c > m_last_rst && m_lastacc[d][c]) v[r] = 1'b1;
        end
        return v;
    endfunction

    // Model update: consume the inputs of cycle `cyc` at its closing edge.
    initial forever begin
        @(posedge clk);
        if (cyc >= NCYC) begin
            $display("FAIL model_depth: cycle %0d exceeds history %0d", cyc, NCYC);
            $fatal(1, "model history exhausted");
        end
        for (int d = 0; d < 2; d++) begin
            bit rdy, acc;
            rdy = !reset && !(cyc <= m_flush_end[d]);
            acc = in_valid[d] && rdy;
            m_inj[d][cyc]     = acc ? in_data[d] : 64'h0;
            m_lastacc[d][cyc] = acc && in_last[d];
            if (reset) begin
                m_streaming[d] = 1'b0;
                m_flush_end[d] = -1;
                m_k[d]         = 16'h0;
            end else if (acc) begin
                if (!m_streaming[d])          m_k[d] = 16'h1;
                else if (m_k[d] != 16'hFFFF)  m_k[d] = m_k[d] + 16'h1;
                if (in_last[d]) begin
                    m_streaming[d] = 1'b0;
                    m_flush_end[d] = cyc + ROWS_CFG[d] + DD_CFG[d];
                end else begin
                    m_streaming[d] = 1'b1;
                end
            end
        end
        if (reset) m_last_rst = cyc;
        cyc++;
    end

    // Compare every output of both instances against the model mid-cycle.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("m4_s_ready", 64'(rdy4), 64'(!reset && !(cyc <= m_flush_end[0])));
            check("m4_busy", 64'(busy4), 64'(m_streaming[0] || cyc <= m_flush_end[0]));
            check("m4_k_count", 64'(k4), 64'(m_k[0]));
            check("m4_out_a", out_a4, exp_out(0, cyc));
            check("m4_done", 64'(done4), 64'(exp_done(0, cyc)));
            check("m1_s_ready", 64'(rdy1), 64'(!reset && !(cyc <= m_flush_end[1])));
            check("m1_busy", 64'(busy1), 64'(m_streaming[1] || cyc <= m_flush_end[1]));
            check("m1_k_count", 64'(k1), 64'(m_k[1]));
            check("m1_out_a", 64'(out_a1), exp_out(1, cyc));
            check("m1_done", 64'(done1), 64'(exp_done(1, cyc)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_mid();
        @(negedge clk);
    endtask

    task automatic drive(input int d, input logic v, input logic [63:0] data, input logic last);
        in_valid[d] = v;
        in_data[d]  = data;
        in_last[d]  = last;
    endtask

    task automatic settle(input int n);
        drive(0, 1'b0, 64'h0, 1'b0);
        drive(1, 1'b0, 64'h0, 1'b0);
        repeat (n) tick();
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 1'b0, 64'h0, 1'b0);
        drive(1, 1'b0, 64'h0, 1'b0);
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        at_mid();
        check("rst_out_a", out_a4, 64'h0);
        check("rst_done", 64'(done4), 64'h0);
        check("rst_busy", 64'(busy4), 64'h0);
        check("rst_k_count", 64'(k4), 64'h0);
        check("rst_s_ready", 64'(rdy4), 64'h1);
        tick();

        // Single column with s_last.
        drive(0, 1'b1, 64'h4400_4200_4000_3C00, 1'b1);
        tick();
        drive(0, 1'b0, 64'h0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            at_mid();
            check("t1_out_a", out_a4, T1_OUT[k-1]);
            check("t1_done", 64'(done4), 64'(T1_DONE[k-1]));
            check("t1_s_ready", 64'(rdy4), 64'(k == 8));
            check("t1_busy", 64'(busy4), 64'(k != 8));
            tick();
        end
        settle(2);

        // Three-column stream, every row 1.0 / 2.0 / 3.0.
        drive(0, 1'b1, {4{16'h3C00}}, 1'b0); tick();
        drive(0, 1'b1, {4{16'h4000}}, 1'b0); tick();
        drive(0, 1'b1, {4{16'h4200}}, 1'b1); tick();
        drive(0, 1'b0, 64'h0, 1'b0);
        for (int k = 3; k <= 8; k++) begin
            at_mid();
            if (k <= 5) check("t2_row2", 64'(out_a4[47:32]), 64'(T2_ROW2[k-3]));
            if (k == 3) check("t2_k_count", 64'(k4), 64'd3);
            if (k == 8) check("t2_done", 64'(done4), 64'h4);
            tick();
        end
        settle(3);

        // Bubble at cycle 1, with a stray s_last that must be ignored.
        drive(0, 1'b1, {4{16'h3C00}}, 1'b0); tick();
        drive(0, 1'b0, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1); tick();
        drive(0, 1'b1, {4{16'h4000}}, 1'b0);
        at_mid();
        check("t3_bubble_out_a", out_a4, 64'h0000_0000_3C00_0000);
        check("t3_busy_after_stray_last", 64'(busy4), 64'h1);
        tick();
        drive(0, 1'b1, {4{16'h4200}}, 1'b1); tick();
        drive(0, 1'b0, 64'h0, 1'b0);
        for (int k = 4; k <= 7; k++) begin
            at_mid();
            if (k == 4) check("t3_wavefront", out_a4, 64'h3C00_0000_4000_4200);
            if (k == 4) check("t3_k_count", 64'(k4), 64'd3);
            if (k == 7) check("t3_done", 64'(done4), 64'h1);
            tick();
        end
        settle(4);

        // Backpressure: s_valid held through FLUSH.
        drive(0, 1'b1, {4{16'h3800}}, 1'b1); tick();
        drive(0, 1'b1, 64'h5300_5200_5100_5000, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            at_mid();
            if (k == 7) check("t4_ready_flush", 64'(rdy4), 64'h0);
            if (k == 8) check("t4_ready_idle", 64'(rdy4), 64'h1);
            tick();
        end
        drive(0, 1'b1, {4{16'h5400}}, 1'b1);
        at_mid();
        check("t4_k_reload", 64'(k4), 64'd1);
        check("t4_busy", 64'(busy4), 64'h1);
        check("t4_row0", 64'(out_a4[15:0]), 64'h5000);
        tick();
        drive(0, 1'b0, 64'h0, 1'b0);
        at_mid();
        check("t4_k_count", 64'(k4), 64'd2);
        tick();
        settle(8);

        // Reset in the middle of a stream.
        drive(0, 1'b1, {4{16'h3C00}}, 1'b0); tick();
        drive(0, 1'b1, {4{16'h4000}}, 1'b0); tick();
        reset = 1'b1;
        drive(0, 1'b1, {4{16'h4200}}, 1'b0);
        at_mid();
        check("t5_ready_in_reset", 64'(rdy4), 64'h0);
        check("t5_ready1_in_reset", 64'(rdy1), 64'h0);
        tick();
        reset = 1'b0;
        drive(0, 1'b0, 64'h0, 1'b0);
        at_mid();
        check("t5_out_a", out_a4, 64'h0);
        check("t5_busy", 64'(busy4), 64'h0);
        check("t5_k_count", 64'(k4), 64'h0);
        check("t5_s_ready", 64'(rdy4), 64'h1);
        tick();
        settle(10);

        // Reset in the middle of FLUSH: done[0] already out, later rows suppressed.
        drive(0, 1'b1, {4{16'h3C00}}, 1'b1); tick();
        settle(3);
        reset = 1'b1;
        at_mid();
        check("t5b_done0_before_reset", 64'(done4), 64'h1);
        tick();
        reset = 1'b0;
        at_mid();
        check("t5b_done_suppressed", 64'(done4), 64'h0);
        check("t5b_s_ready", 64'(rdy4), 64'h1);
        check("t5b_busy", 64'(busy4), 64'h0);
        tick();
        settle(8);

        // ROWS=1, DONE_DELAY=0 corner.
        drive(1, 1'b1, 64'h3C00, 1'b1); tick();
        drive(1, 1'b0, 64'h0, 1'b0);
        at_mid();
        check("t6_out_a", 64'(out_a1), 64'h3C00);
        check("t6_done", 64'(done1), 64'h1);
        check("t6_ready_flush", 64'(rdy1), 64'h0);
        check("t6_busy", 64'(busy1), 64'h1);
        tick();
        at_mid();
        check("t6_ready_idle", 64'(rdy1), 64'h1);
        check("t6_busy_idle", 64'(busy1), 64'h0);
        tick();
        drive(1, 1'b1, 64'h4000, 1'b0); tick();
        drive(1, 1'b1, 64'h4200, 1'b1);
        at_mid();
        check("t6_stream_out0", 64'(out_a1), 64'h4000);
        tick();
        drive(1, 1'b0, 64'h0, 1'b0);
        at_mid();
        check("t6_stream_out1", 64'(out_a1), 64'h4200);
        check("t6_stream_done", 64'(done1), 64'h1);
        check("t6_k_count", 64'(k1), 64'd2);
        check("t6_flush_one_cycle", 64'(rdy1), 64'h0);
        tick();
        settle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
